fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage for the 18-bit processor. It owns the program counter, drives the address of the combinational instruction ROM, and captures the returned word into an output register. That register feeds the decode stage through a valid/ready handshake. It also handles branch/jump redirects from execute, halts on request, and counts fetched instructions.

## Interface
Parameters:
- ADDR_W, 10, PC / ROM address width
- INSTR_W, 18, instruction width
- RESET_PC, 10'd0, PC value after reset
- CNT_W, 16, width of the fetch counter

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rom_addr  out  ADDR_W  address to instruction ROM; rom_addr = pc, combinational
- rom_q  in  INSTR_W  ROM data for rom_addr, valid in the same cycle
- instr_valid  out  1  output register holds an instruction
- instr_ready  in  1  decode accepts instruction this cycle
- instr  out  INSTR_W  fetched instruction
- instr_pc  out  ADDR_W  address instr was fetched from
- redirect_valid  in  1  branch/jump taken, flush and restart
- redirect_pc  in  ADDR_W  new fetch address
- halt_req  in  1  one-cycle pulse from decode: stop fetching
- halted  out  1  FSM in HALTED
- fetch_count  out  CNT_W  number of instructions accepted by decode, saturating

## Operation
FSM, state fetch_state_t:
- RUN: normal fetching.
- HALTED: no loads; pc frozen.

Signal definitions:
- load_en = (state==RUN) && !redirect_valid && !halt_req && (!instr_valid || instr_ready).
- fire = instr_valid && instr_ready.

Priority per cycle (highest first):
1. redirect_valid:
   - pc <= redirect_pc, instr_valid <= 0 (flush, including an unaccepted instruction).
   - state <= RUN, even from HALTED.
   - halt_req in the same cycle is ignored.
   - fetch_count still increments if fire.
2. halt_req (state RUN):
   - state <= HALTED, no load this cycle.
   - instr_valid <= 0 if fire, else holds.
3. load_en:
   - instr <= rom_q, instr_pc <= pc, instr_valid <= 1.
   - pc <= pc + 1, wrapping modulo 2^ADDR_W (1023 -> 0).
4. Otherwise (stall, or HALTED):
   - instr, instr_pc, pc hold.
   - instr_valid <= 0 only if fire.

Output rules:
- fetch_count increments on every fire and saturates at 2^CNT_W-1.
- instr/instr_pc stay stable while instr_valid && !instr_ready.
- halted = (state==HALTED).

## Timing
Reset values (asynchronous, while rst_n low):
- pc = RESET_PC
- state = RUN
- instr_valid = 0, instr = 0, instr_pc = 0
- fetch_count = 0
- rom_addr = RESET_PC

Latencies:
- Fetch: ROM addressed in cycle N, instruction valid in cycle N+1.
- Throughput: one instruction per cycle while instr_ready=1.
- Redirect asserted in cycle N: instr_valid=0 in N+1; instruction at redirect_pc valid in N+2 (one bubble).
- halt_req in cycle N: halted=1 in N+1. An instruction already in the register remains offered until accepted.

Reset mid-operation: all state returns to reset values immediately; the in-flight instruction is discarded.

## Structure
Shared package proc_pkg holds:
- ADDR_W, INSTR_W, RESET_PC constants
- fetch_state_t enum {RUN, HALTED}
- Typedefs pc_t (logic [ADDR_W-1:0]) and instr_t (logic [INSTR_W-1:0]), used by the ROM, fetch and decode.

No sub-module: a single flat module holds the pc register, output register, FSM and counter.

## Test plan
- Reset release with ROM[0..3] = 18'h00001..18'h00004, instr_ready=1: outputs 1,2,3,4 on consecutive cycles with instr_pc 0,1,2,3; fetch_count=4.
- Backpressure: instr_ready=0 for 3 cycles while valid with instr_pc=5. instr and instr_pc hold, pc stays 6. After ready returns, next instr_pc=6; no instruction is lost or duplicated.
- Redirect to 10'h200 while an unaccepted instruction at pc 7 is valid: instr_valid=0 next cycle, then instr_pc=10'h200 with ROM[0x200]. The pc-7 instruction is never accepted.
- Wrap: redirect to 10'h3FF, ready=1: instr_pc sequence is 3FF, 000, 001.
- Halt, then redirect: halt_req pulse means halted=1, valid drops after acceptance, rom_addr frozen for 10 cycles. A later redirect_valid to 10'h040 gives halted=0 and fetching resumes at 040. Also drive halt_req and redirect in the same cycle: redirect wins and halted stays 0.
- rst_n asserted mid-stream while valid and stalled: instr_valid=0, pc=RESET_PC and fetch_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/proc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | proc_pkg                                                             |
// | Shared constants and types for the 18-bit processor pipeline.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package proc_pkg;

  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 18;
  localparam logic [ADDR_W-1:0] RESET_PC = 10'd0;

  typedef logic [ADDR_W-1:0]  pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit                                                           |
// | Instruction fetch: PC, ROM addressing, output register with          |
// | valid/ready handshake, redirect/halt handling and fetch counter.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_unit
  import proc_pkg::fetch_state_t, proc_pkg::RUN, proc_pkg::HALTED;
#(
  parameter int                ADDR_W   = proc_pkg::ADDR_W,
  parameter int                INSTR_W  = proc_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = proc_pkg::RESET_PC,
  parameter int                CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_q,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  fetch_state_t       r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic [CNT_W-1:0]   r_count;

  logic w_fire;
  logic w_load_en;

  assign w_fire    = r_valid && instr_ready;
  assign w_load_en = (r_state == RUN) && !redirect_valid && !halt_req &&
                     (!r_valid || instr_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else if (redirect_valid) begin
      // Flush wins over everything, including a pending halt and HALTED.
      r_state <= RUN;
      r_pc    <= redirect_pc;
      r_valid <= 1'b0;
    end else if (halt_req && (r_state == RUN)) begin
      r_state <= HALTED;
      if (w_fire) begin
        r_valid <= 1'b0;
      end
    end else if (w_load_en) begin
      r_instr    <= rom_q;
      r_instr_pc <= r_pc;
      r_valid    <= 1'b1;
      r_pc       <= r_pc + 1'b1;
    end else if (w_fire) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_fire && (r_count != c_cnt_max)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign rom_addr    = r_pc;
  assign instr_valid = r_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign halted      = (r_state == HALTED);
  assign fetch_count = r_count;

endmodule
`default_nettype wire
